// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and default operand width.
// Divider support is selected by the ALU_DIV_EN macro (see alu.sv).
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_SHR  = 5'd4,
    OP_SHL  = 5'd5,
    OP_NOT  = 5'd6,
    OP_ROL  = 5'd7,
    OP_ROR  = 5'd8,
    OP_SHRA = 5'd9,
    OP_MUL  = 5'd10,
    OP_DIV  = 5'd11,
    OP_NEG  = 5'd12,
    OP_XOR  = 5'd13
  } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between an ALU and whatever drives it.
interface alu_if #(
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0]   input_a;
  logic [DATA_W-1:0]   input_b;
  logic [4:0]          opcode;
  logic [2*DATA_W-1:0] ALU_result;

  modport master (output input_a, output input_b, output opcode, input ALU_result);
  modport slave  (input input_a, input input_b, input opcode, output ALU_result);

endinterface

// File: rtl/alu_div.sv
// Combinational signed divider: quotient truncates toward zero, remainder follows the dividend's sign.
module alu_div #(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] dividend,
  input  logic signed [DATA_W-1:0] divisor,
  output logic signed [DATA_W-1:0] quotient,
  output logic signed [DATA_W-1:0] remainder
);

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  // The two overflow-prone cases are resolved explicitly so the result never depends on tool behaviour.
  always_comb begin
    quotient  = '0;
    remainder = '0;
    if (divisor == '0) begin
      quotient  = '1;
      remainder = dividend;
    end else if ((dividend == MOST_NEG) && (divisor == '1)) begin
      quotient  = dividend;
      remainder = '0;
    end else begin
      quotient  = dividend / divisor;
      remainder = dividend % divisor;
    end
  end

endmodule

// File: rtl/alu.sv
// Single-cycle ALU with one registered result (HI:LO). The divider for opcode 11
// is only built when ALU_DIV_EN is defined; otherwise opcode 11 returns zero.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic   clock,
  input  logic   clear,
  alu_if.slave   bus
);

  localparam int RES_W = 2 * DATA_W;

  logic        [DATA_W-1:0] a_u;
  logic        [DATA_W-1:0] b_u;
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [RES_W-1:0]  a_ext;
  logic signed [RES_W-1:0]  b_ext;
  logic signed [RES_W-1:0]  mul_full;
  logic        [4:0]        sh;
  logic        [RES_W-1:0]  result_d;
  logic        [RES_W-1:0]  result_q;

  function automatic logic [RES_W-1:0] lo_only(input logic [DATA_W-1:0] v);
    return {{DATA_W{1'b0}}, v};
  endfunction

  assign a_u   = bus.input_a;
  assign b_u   = bus.input_b;
  assign a_s   = bus.input_a;
  assign b_s   = bus.input_b;
  assign sh    = b_u[4:0];
  assign a_ext = {{DATA_W{a_s[DATA_W-1]}}, a_s};
  assign b_ext = {{DATA_W{b_s[DATA_W-1]}}, b_s};
  assign mul_full = a_ext * b_ext;

`ifdef ALU_DIV_EN
  logic signed [DATA_W-1:0] div_quo;
  logic signed [DATA_W-1:0] div_rem;

  alu_div #(.DATA_W(DATA_W)) u_div (
    .dividend (a_s),
    .divisor  (b_s),
    .quotient (div_quo),
    .remainder(div_rem)
  );
`endif

  // Rotates rely on a shift by DATA_W yielding zero, so amount 0 passes A through.
  always_comb begin
    result_d = '0;
    case (bus.opcode)
      OP_ADD:  result_d = lo_only(a_u + b_u);
      OP_SUB:  result_d = lo_only(a_u - b_u);
      OP_AND:  result_d = lo_only(a_u & b_u);
      OP_OR:   result_d = lo_only(a_u | b_u);
      OP_SHR:  result_d = lo_only(a_u >> sh);
      OP_SHL:  result_d = lo_only(a_u << sh);
      OP_NOT:  result_d = lo_only(~a_u);
      OP_ROL:  result_d = lo_only((a_u << sh) | (a_u >> (DATA_W - int'(sh))));
      OP_ROR:  result_d = lo_only((a_u >> sh) | (a_u << (DATA_W - int'(sh))));
      OP_SHRA: result_d = lo_only(a_s >>> sh);
      OP_MUL:  result_d = mul_full;
`ifdef ALU_DIV_EN
      OP_DIV:  result_d = {div_rem, div_quo};
`else
      OP_DIV:  result_d = '0;
`endif
      OP_NEG:  result_d = lo_only(-a_u);
      OP_XOR:  result_d = lo_only(a_u ^ b_u);
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign bus.ALU_result = result_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases, randomized stimulus against a longint reference model, clear behaviour.
module tb_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic clear;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  alu_if #(.DATA_W(32)) bus ();

  alu #(.DATA_W(32)) dut (
    .clock(clk),
    .clear(clear),
    .bus  (bus)
  );

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  // Reference model computed with 64-bit integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] t;
    logic [63:0] dd;
    int          s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = int'(b[4:0]);
    dd = {a, a};
    t  = '0;
    case (op)
      5'd0:  t = {32'd0, a + b};
      5'd1:  t = {32'd0, a - b};
      5'd2:  t = {32'd0, a & b};
      5'd3:  t = {32'd0, a | b};
      5'd4:  t = {32'd0, a >> s};
      5'd5:  t = {32'd0, a << s};
      5'd6:  t = {32'd0, ~a};
      5'd7:  begin t = dd >> (32 - s); t = {32'd0, t[31:0]}; end
      5'd8:  begin t = dd >> s;        t = {32'd0, t[31:0]}; end
      5'd9:  begin t = sa >>> s;       t = {32'd0, t[31:0]}; end
      5'd10: t = sa * sb;
      5'd11: begin
`ifdef ALU_DIV_EN
        if (b == 32'd0) t = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) t = {32'd0, 32'h8000_0000};
        else begin
          q = sa / sb;
          r = sa % sb;
          t = {r[31:0], q[31:0]};
        end
`else
        t = '0;
`endif
      end
      5'd12: t = {32'd0, 32'd0 - a};
      5'd13: t = {32'd0, a ^ b};
      default: t = '0;
    endcase
    return t;
  endfunction

  task automatic drive(input logic clr, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    clear         = clr;
    bus.opcode    = op;
    bus.input_a   = a;
    bus.input_b   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(OP_MUL), $urandom | 32'h1, $urandom | 32'h1);
      vecs++;
      if (bus.ALU_result !== 64'd0) begin
        $display("FAIL reset[%0d] got=%h want=%h", i, bus.ALU_result, 64'd0);
        errs++;
      end
    end
  endtask

  task automatic test_directed();
    vec_t vq[$];
    vec_t v;
    vq.push_back({OP_ADD,  32'd2,          32'd3,          64'd5});
    vq.push_back({OP_SUB,  32'd2,          32'd3,          64'h0000_0000_FFFF_FFFF});
    vq.push_back({OP_AND,  32'd12,         32'd17,         64'd0});
    vq.push_back({OP_OR,   32'd17,         32'd20,         64'd21});
    vq.push_back({OP_SHR,  32'd17,         32'd4,          64'd1});
    vq.push_back({OP_SHL,  32'd17,         32'd3,          64'd136});
    vq.push_back({OP_ROL,  32'd17,         32'd5,          64'h220});
    vq.push_back({OP_ROR,  32'd17,         32'd5,          64'h8800_0000});
    vq.push_back({OP_SHRA, 32'hFFFF_FFEF,  32'd3,          64'h0000_0000_FFFF_FFFD});
    vq.push_back({OP_MUL,  32'd17,         32'd17,         64'd289});
    vq.push_back({OP_MUL,  32'hFFFF_FFFA,  32'd5,          64'hFFFF_FFFF_FFFF_FFE2});
    vq.push_back({OP_MUL,  32'hFFFF_FFEF,  32'hFFFF_FFF7,  64'd153});
    vq.push_back({OP_MUL,  32'd8,          32'd24,         64'd192});
    vq.push_back({OP_MUL,  32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001});
    vq.push_back({OP_NOT,  32'h0F0F_0F0F,  32'h1234_5678,  64'h0000_0000_F0F0_F0F0});
    vq.push_back({OP_NEG,  32'd5,          32'd9,          64'h0000_0000_FFFF_FFFB});
    vq.push_back({OP_XOR,  32'h0000_FF00,  32'h0000_0FF0,  64'h0000_F0F0});
    vq.push_back({OP_SHL,  32'hDEAD_BEEF,  32'h0000_0020,  64'h0000_0000_DEAD_BEEF});
    vq.push_back({OP_ROR,  32'hDEAD_BEEF,  32'd0,          64'h0000_0000_DEAD_BEEF});
    vq.push_back({OP_SHRA, 32'h8000_0000,  32'd31,         64'h0000_0000_FFFF_FFFF});
`ifdef ALU_DIV_EN
    vq.push_back({OP_DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFD,  64'hFFFF_FFFE_0000_0002});
    vq.push_back({OP_DIV,  32'd7,          32'd0,          64'h0000_0007_FFFF_FFFF});
    vq.push_back({OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  64'h0000_0000_8000_0000});
    vq.push_back({OP_DIV,  32'd7,          32'hFFFF_FFFE,  64'h0000_0001_FFFF_FFFD});
`else
    vq.push_back({OP_DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFD,  64'd0});
    vq.push_back({OP_DIV,  32'd7,          32'd0,          64'd0});
`endif
    vq.push_back({5'd14,   32'd5,          32'd6,          64'd0});
    vq.push_back({5'd31,   32'hFFFF_FFFF,  32'd77,         64'd0});
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      drive(1'b0, v.op, v.a, v.b);
      vecs++;
      if (bus.ALU_result !== v.exp) begin
        $display("FAIL directed[%0d] op=%0d a=%h b=%h got=%h want=%h", i, v.op, v.a, v.b, bus.ALU_result, v.exp);
        errs++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          pick;
    for (int i = 0; i < 400; i++) begin
      op   = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 13)) : 5'($urandom_range(14, 31));
      a    = $urandom;
      b    = $urandom;
      pick = $urandom_range(0, 19);
      if (pick == 0) b = 32'd0;
      else if (pick == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (pick < 6) begin a = 32'($signed($urandom_range(0, 200)) - 100); b = 32'($signed($urandom_range(0, 20)) - 10); end
      exp = ref_model(op, a, b);
      drive(1'b0, op, a, b);
      vecs++;
      if (bus.ALU_result !== exp) begin
        $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, bus.ALU_result, exp);
        errs++;
      end
      if ((i % 16) == 0) begin
        #3;
        vecs++;
        if (bus.ALU_result !== exp) begin
          $display("FAIL hold[%0d] got=%h want=%h", i, bus.ALU_result, exp);
          errs++;
        end
      end
    end
  endtask

  task automatic test_clear_mid();
    drive(1'b0, 5'(OP_MUL), 32'd3, 32'd4);
    vecs++;
    if (bus.ALU_result !== 64'd12) begin
      $display("FAIL clear_pre got=%h want=%h", bus.ALU_result, 64'd12);
      errs++;
    end
    drive(1'b1, 5'(OP_MUL), 32'd5, 32'd6);
    vecs++;
    if (bus.ALU_result !== 64'd0) begin
      $display("FAIL clear_hit got=%h want=%h", bus.ALU_result, 64'd0);
      errs++;
    end
    drive(1'b0, 5'(OP_MUL), 32'd11, 32'd13);
    vecs++;
    if (bus.ALU_result !== 64'd143) begin
      $display("FAIL clear_release got=%h want=%h", bus.ALU_result, 64'd143);
      errs++;
    end
    drive(1'b0, 5'(OP_MUL), 32'hFFFF_FFF9, 32'd9);
    vecs++;
    if (bus.ALU_result !== 64'hFFFF_FFFF_FFFF_FFC1) begin
      $display("FAIL clear_after got=%h want=%h", bus.ALU_result, 64'hFFFF_FFFF_FFFF_FFC1);
      errs++;
    end
    drive(1'b1, 5'(OP_ADD), 32'd1, 32'd1);
    vecs++;
    if (bus.ALU_result !== 64'd0) begin
      $display("FAIL clear_add got=%h want=%h", bus.ALU_result, 64'd0);
      errs++;
    end
  endtask

  initial begin
    clear       = 1'b1;
    bus.opcode  = 5'd0;
    bus.input_a = 32'd0;
    bus.input_b = 32'd0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_clear_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
- REQ-001: Parameter DATA_W, default 32, operand width; result is 2*DATA_W bits wide.
- REQ-002: clock  input  1  rising-edge clock for the registered output.
- REQ-003: clear  input  1  reset, synchronous and active-high.
- REQ-004: input_a  input  DATA_W  operand A, two's complement.
- REQ-005: input_b  input  DATA_W  operand B, two's complement; shift/rotate amount is input_b[4:0].
- REQ-006: opcode  input  5  operation select.
- REQ-007: ALU_result  output  2*DATA_W  registered result; bits [DATA_W-1:0] are "LO" and bits [2*DATA_W-1:DATA_W] are "HI".

Function
- REQ-008: Opcode map SHALL be:
  - 0 ADD: A+B, carry discarded.
  - 1 SUB: A-B.
  - 2 AND.
  - 3 OR.
  - 4 SHR: logical right.
  - 5 SHL.
  - 6 NOT: ~A, B ignored.
  - 7 ROL.
  - 8 ROR.
  - 9 SHRA: arithmetic right.
  - 10 MUL: signed.
  - 11 DIV: signed.
  - 12 NEG: -A.
  - 13 XOR.
- REQ-009: For all opcodes except MUL and DIV, the result SHALL be placed in LO, with HI = 0.
- REQ-010: MUL SHALL produce the full 2*DATA_W-bit signed product across HI:LO.
- REQ-011: DIV SHALL put the quotient, truncated toward zero, in LO and the remainder in HI; the remainder takes the sign of A.
- REQ-012: DIV by zero SHALL give LO = all-ones and HI = A; no trap.
- REQ-013: DIV of most-negative by -1 SHALL give LO = most-negative and HI = 0.
- REQ-014: Shift/rotate amount SHALL be B[4:0]; amount 0 passes A unchanged.
- REQ-015: SHRA SHALL fill vacated bits with A[DATA_W-1].
- REQ-016: Opcodes 14-31 SHALL produce an all-zero result.
- REQ-017: Latency SHALL be exactly one clock: ALU_result after edge N reflects the inputs sampled at edge N.
- REQ-018: There is no handshake; a new operation is accepted every cycle.
- REQ-019: The result SHALL hold its value until the next edge.

Reset
- REQ-020: When clear=1 at a rising edge, ALU_result SHALL become 0, overriding any operation in that cycle.
- REQ-021: On the first edge after clear falls, the result SHALL be computed normally from the inputs present.
- REQ-022: Asserting clear mid-stream SHALL discard the pending result, with no residual state.

Configuration
- REQ-023: Macro ALU_DIV_EN: when defined, the divider is built and opcode 11 operates per REQ-011 to REQ-013.
- REQ-024: When ALU_DIV_EN is not defined, no divider logic SHALL exist and opcode 11 SHALL return all-zero, the same as an undefined opcode.

Structure
- REQ-025: Package alu_pkg SHALL hold the opcode constants/enum (ADD through XOR) and the DATA_W default.
- REQ-026: The divider SHALL be sub-module alu_div, a combinational signed divider producing quotient and remainder, instantiated only under ALU_DIV_EN.
- REQ-027: All other operations SHALL be inline combinational logic feeding one output register.

Verification
- REQ-028: ADD A=2, B=3, then SUB same operands: result 0x0000_0000_0000_0005, then LO=0xFFFF_FFFF with HI=0, each one clock after apply.
- REQ-029: Logic and shift cases:
  - AND 12,17 gives 0.
  - OR 17,20 gives 21.
  - SHR 17,4 gives 1.
  - SHL 17,3 gives 136.
  - ROL 17,5 gives 0x220.
  - ROR 17,5 gives 0x8800_0000.
  - SHRA -17,3 gives LO=0xFFFF_FFFD, HI=0.
- REQ-030: MUL cases:
  - 17*17 gives 289.
  - -6*5 gives 0xFFFF_FFFF_FFFF_FFE2.
  - -17*-9 gives 153.
  - 8*24 gives 192.
  - 0x7FFF_FFFF squared gives 0x3FFF_FFFF_0000_0001.
- REQ-031: DIV cases (with ALU_DIV_EN):
  - -8/-3 gives LO=2, HI=0xFFFF_FFFE.
  - 7/0 gives LO=0xFFFF_FFFF, HI=7.
  - Without the macro, -8/-3 gives 0.
- REQ-032: Reset behaviour: assert clear during a MUL stream; result is 0 at that edge, then the correct product on the first edge after release.
- REQ-033: Opcodes 14 and 31 with nonzero operands give 0.
